// File: rtl/prio_rr_arbiter.sv
// rtl/prio_rr_arbiter.sv - fixed-priority / round-robin arbiter with hold limit
module prio_rr_arbiter #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // Counter value seen in the last permitted hold cycle; the release fires on that edge.
  localparam logic [CW-1:0] HIT_VAL = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            tout_q, tout_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    cand;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            arb;
  logic            hit;

  // Candidate set: the current holder is excluded from the decision that releases it.
  always_comb begin
    cand = req;
    if (state_q == BUSY) cand[idx_q] = 1'b0;
  end

  // Winner selection: highest index in fixed mode, first at/above ptr (wrapping) in round-robin.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        int j;
        j = (int'(ptr_q) + k) % N;
        if (cand[j]) begin
          win_found = 1'b1;
          win_idx   = IW'(j);
        end
      end
    end
  end

  // Next-state: decide whether to arbitrate this edge and what the registered outputs become.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    arb     = 1'b0;
    hit     = (MAX_HOLD != 0) && (cnt_q == HIT_VAL);

    if (state_q == IDLE) begin
      arb = 1'b1;
    end else if (ack || !req[idx_q] || hit) begin
      arb    = 1'b1;
      tout_d = hit && !ack;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (arb) begin
      cnt_d = '0;
      if (win_found) begin
        state_d = BUSY;
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
        idx_d   = win_idx;
        valid_d = 1'b1;
        ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = tout_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// tb/tb_prio_rr_arbiter.sv - self-checking bench for prio_rr_arbiter
module tb_prio_rr_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       ack = 1'b0;

  logic [3:0] g [2];
  logic [1:0] gi [2];
  logic       gv [2];
  logic       to [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prio_rr_arbiter #(.N(N), .MODE(0), .MAX_HOLD(HOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(g[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0]), .timeout(to[0]));

  prio_rr_arbiter #(.N(N), .MODE(1), .MAX_HOLD(HOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(g[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1]), .timeout(to[1]));

  // Reference model: holder index (-1 = none), cycles the grant has been visible, rr pointer.
  int holder [2];
  int held   [2];
  int ptr    [2];
  bit tout   [2];
  int m_win;
  bit m_rel;
  logic [3:0] m_cand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        holder[k] = -1; held[k] = 0; ptr[k] = 0; tout[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_rel = (holder[k] < 0) || ack || !req[holder[k]] || (held[k] == HOLD);
        if (m_rel) begin
          tout[k] = (holder[k] >= 0) && (held[k] == HOLD) && !ack;
          m_cand = req;
          if (holder[k] >= 0) m_cand[holder[k]] = 1'b0;
          m_win = -1;
          if (k == 0) begin
            for (int i = N - 1; i >= 0; i--)
              if (m_cand[i] && m_win < 0) m_win = i;
          end else begin
            for (int off = 0; off < N; off++)
              if (m_cand[(ptr[k] + off) % N] && m_win < 0) m_win = (ptr[k] + off) % N;
          end
          holder[k] = m_win;
          held[k]   = (m_win >= 0) ? 1 : 0;
          if (m_win >= 0) ptr[k] = (m_win + 1) % N;
        end else begin
          held[k] = held[k] + 1;
          tout[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt%0d", k), 32'(g[k]), (holder[k] >= 0) ? (32'd1 << holder[k]) : 32'd0);
      chk($sformatf("idx%0d", k), 32'(gi[k]), (holder[k] >= 0) ? 32'(holder[k]) : 32'd0);
      chk($sformatf("valid%0d", k), 32'(gv[k]), 32'(holder[k] >= 0));
      chk($sformatf("timeout%0d", k), 32'(to[k]), 32'(tout[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_gnt", 32'(g[k]), 32'd0);
      chk("rst_valid", 32'(gv[k]), 32'd0);
      chk("rst_timeout", 32'(to[k]), 32'd0);
    end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Fixed priority basics and holder withdraw.
    req = 4'b0110; tick();
    chk("fp_0110_gnt", 32'(g[0]), 32'h4);
    chk("fp_0110_idx", 32'(gi[0]), 32'd2);
    chk("fp_0110_valid", 32'(gv[0]), 32'd1);
    req = 4'b0001; tick();
    chk("fp_0001_gnt", 32'(g[0]), 32'h1);
    req = 4'b1000; tick();
    chk("wd_hold_gnt", 32'(g[0]), 32'h8);
    req = 4'b0001; tick();
    chk("wd_new_gnt", 32'(g[0]), 32'h1);
    chk("wd_timeout", 32'(to[0]), 32'd0);
    req = 4'b0000; tick();
    chk("idle_gnt", 32'(g[0]), 32'd0);

    // Round-robin order with ack every grant, no bubbles.
    do_reset();
    req = 4'b1111; tick();
    chk("rr_first", 32'(g[1]), 32'h1);
    ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("rr_order%0d", i), 32'(gi[1]), 32'(i % N));
      chk($sformatf("rr_valid%0d", i), 32'(gv[1]), 32'd1);
    end
    ack = 1'b0;

    // Hold limit, then another requester present.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk($sformatf("hold_gnt%0d", i), 32'(g[0]), 32'h2);
      chk($sformatf("hold_to%0d", i), 32'(to[0]), 32'd0);
    end
    req = 4'b0011; tick();
    chk("to_mask_gnt", 32'(g[0]), 32'h1);
    chk("to_mask_pulse", 32'(to[0]), 32'd1);
    tick();
    chk("to_pulse_end", 32'(to[0]), 32'd0);

    // Hold limit with only the holder requesting.
    do_reset();
    req = 4'b0010;
    repeat (HOLD) tick();
    tick();
    chk("to_alone_gnt", 32'(g[0]), 32'd0);
    chk("to_alone_pulse", 32'(to[0]), 32'd1);

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b0100; tick();
    chk("mid_pre_gnt", 32'(g[0]), 32'h4);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(g[0]), 32'd0);
    chk("mid_rst_valid", 32'(gv[0]), 32'd0);
    #2 rst_n = 1'b1;
    req = 4'b1111; tick();
    chk("mid_rr_ptr", 32'(g[1]), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4: number of requesters, legal range 2..32.
REQ-002 The block SHALL have parameter MODE, default 0: 0 = fixed priority with the highest index winning, 1 = round-robin.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16: maximum grant cycles before forced release; 0 disables the limit.
REQ-004 The block SHALL have a single clock and reset: clk input 1, the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have reset input rst_n, width 1, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, width N: request lines, level-sensitive, one per requester.
REQ-007 The block SHALL have port ack, input, width 1: current grant holder signals done; ignored while no grant is active.
REQ-008 The block SHALL have port gnt, output, width N: registered one-hot grant, or all-zero.
REQ-009 The block SHALL have port gnt_idx, output, width clog2(N): binary index of the granted requester; 0 when no grant.
REQ-010 The block SHALL have port gnt_valid, output, width 1: high exactly when gnt is non-zero.
REQ-011 The block SHALL have port timeout, output, width 1: one-cycle pulse on forced release.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and BUSY; gnt, gnt_idx, gnt_valid and timeout are registered, with no combinational path from input to output.
REQ-013 In IDLE with req != 0, the block SHALL select the winner and drive gnt/gnt_idx/gnt_valid on the next rising edge (latency 1), then enter BUSY.
REQ-014 In IDLE with req == 0, all outputs SHALL stay zero.
REQ-015 In MODE 0, the winner SHALL be the highest set index of req.
REQ-016 In MODE 1, the winner SHALL be the first set req at or above pointer ptr, scanning upward and wrapping from N-1 to 0.
REQ-017 In MODE 1, on every new grant ptr SHALL become (winner+1) mod N.
REQ-018 In BUSY, gnt SHALL hold constant until a release event occurs.
REQ-019 Release events in BUSY SHALL be:
- ack = 1;
- req[gnt_idx] = 0 (holder withdrew);
- hold counter reaching MAX_HOLD.
REQ-020 On a release event, the block SHALL re-arbitrate among the current req, with the holder's bit masked off for that one decision; if any other request is present it is granted on the next edge (no idle bubble), otherwise the block returns to IDLE with outputs zero.
REQ-021 Simultaneous ack and timeout condition SHALL be treated as ack; timeout does not pulse.
REQ-022 The hold counter SHALL:
- clear on each new grant;
- increment each BUSY cycle without release;
- use width clog2(MAX_HOLD+1);
- saturate, never wrap.
REQ-023 On forced release, timeout SHALL be 1 for exactly the cycle in which the new gnt value, or zero, appears.
REQ-024 A req bit asserted in the same cycle as a release event SHALL participate in that arbitration.
REQ-025 Requests other than the holder's that change during BUSY SHALL have no effect until release.

Reset
REQ-026 When rst_n = 0, the block SHALL force asynchronously: state = IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, ptr = 0, counter = 0.
REQ-027 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-028 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with req != 0.

Verification
REQ-029 With MODE 0, N=4: req=4'b0110 from IDLE -> next edge gnt=4'b0100, gnt_idx=2, gnt_valid=1; req=4'b0001 -> gnt=4'b0001.
REQ-030 With MODE 1, N=4, all req held at 4'b1111 and ack pulsed each grant -> grant order 0,1,2,3,0, each back-to-back without an idle cycle.
REQ-031 With MAX_HOLD=4: req[1] held and ack never asserted -> gnt stays 4'b0010 for 4 cycles, then timeout=1 for one cycle. Then:
- if req=4'b0011 -> gnt=4'b0001 (holder masked);
- if only req[1] is set -> gnt=0, state IDLE.
REQ-032 Holder withdraw: gnt=4'b1000, req drops to 4'b0001 -> next edge gnt=4'b0001, timeout=0.
REQ-033 Reset mid-grant: gnt=4'b0100, rst_n pulled low between clock edges -> gnt=0, gnt_valid=0 immediately; after release, MODE 1 with req=4'b1111 grants index 0 (ptr reset).
